// File: rtl/esp32_spi_regmem.sv
// Register/memory backend for the ESP32 SPI protocol processor, with a fabric-side memory port.
// Optional doorbell register is enabled by defining ESP32_SPI_DOORBELL_EN.
module esp32_spi_regmem #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned NUM_SPACES = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter logic [7:0]  PROTO_VER  = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wr_req,
  input  logic [6:0]        reg_idx,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_space,
  input  logic [23:0]       mem_wr_addr,
  input  logic [7:0]        mem_wr_data,
  input  logic              mem_rd_req,
  input  logic [2:0]        mem_rd_space,
  input  logic [23:0]       mem_rd_addr,
  output logic              mem_rd_valid,
  output logic [7:0]        mem_rd_data,
  input  logic              fab_req,
  input  logic              fab_we,
  input  logic [1:0]        fab_space,
  input  logic [MEM_AW-1:0] fab_addr,
  input  logic [7:0]        fab_wdata,
  output logic              fab_gnt,
  output logic              fab_rvalid,
  output logic [7:0]        fab_rdata,
  output logic              db_irq,
  output logic [7:0]        db_data,
  input  logic              db_ack
);

  localparam int unsigned DEPTH = NUM_SPACES << MEM_AW;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned RW    = $clog2(NUM_REGS);
`ifdef ESP32_SPI_DOORBELL_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif
  localparam logic [7:0] CAP0 = {5'b0, (RD_LAT == 2), DB_EN, 1'b1};
  localparam logic [7:0] CAP1 = {4'(MEM_AW), 4'(NUM_SPACES)};

  logic [7:0] mem [DEPTH];
  logic [7:0] scratch [NUM_REGS];
  logic [7:0] r8;
  logic       oob_err;
  logic       db_irq_q;

  logic          wr_oob_c, rd_oob_c, fab_oob_c, fab_rd_c, fab_wr_c, sel_oob_c;
  logic [IW-1:0] wr_idx_c, spi_rd_idx_c, fab_idx_c, sel_idx_c;
  logic [7:0]    rd_data_c;
  logic          reg_in_range_c, reg_wr_ok_c, oob_evt_c, oob_clr_c;
  logic [RW-1:0] ridx_c;

  // Bounds checks: no aliasing, any stray high address bit is an error
  assign wr_oob_c  = (mem_space >= 3'(NUM_SPACES)) || (|mem_wr_addr[23:MEM_AW]);
  assign rd_oob_c  = (mem_rd_space >= 3'(NUM_SPACES)) || (|mem_rd_addr[23:MEM_AW]);
  assign fab_oob_c = ({1'b0, fab_space} >= 3'(NUM_SPACES));

  assign wr_idx_c     = IW'({mem_space[1:0], mem_wr_addr[MEM_AW-1:0]});
  assign spi_rd_idx_c = IW'({mem_rd_space[1:0], mem_rd_addr[MEM_AW-1:0]});
  assign fab_idx_c    = IW'({fab_space, fab_addr});

  // SPI owns the single memory port whenever it issues anything
  assign fab_gnt  = fab_req & ~mem_wr_en & ~mem_rd_req;
  assign fab_rd_c = fab_gnt & ~fab_we;
  assign fab_wr_c = fab_gnt & fab_we;

  assign sel_idx_c = mem_rd_req ? spi_rd_idx_c : fab_idx_c;
  assign sel_oob_c = mem_rd_req ? rd_oob_c : fab_oob_c;
  assign rd_data_c = sel_oob_c ? 8'hFF : mem[sel_idx_c];

  always_ff @(posedge clk) begin
    if (mem_wr_en && !wr_oob_c) mem[wr_idx_c] <= mem_wr_data;
    else if (fab_wr_c && !fab_oob_c) mem[fab_idx_c] <= fab_wdata;
  end

  // Read pipeline; reset flushes in-flight requests
  logic       spi_v [RD_LAT];
  logic       fab_v [RD_LAT];
  logic [7:0] spi_d [RD_LAT];
  logic [7:0] fab_d [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        spi_v[i] <= 1'b0;
        fab_v[i] <= 1'b0;
        spi_d[i] <= 8'h00;
        fab_d[i] <= 8'h00;
      end
    end else begin
      spi_v[0] <= mem_rd_req;
      fab_v[0] <= fab_rd_c;
      if (mem_rd_req) spi_d[0] <= rd_data_c;
      if (fab_rd_c) fab_d[0] <= rd_data_c;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        spi_v[i] <= spi_v[i-1];
        fab_v[i] <= fab_v[i-1];
        if (spi_v[i-1]) spi_d[i] <= spi_d[i-1];
        if (fab_v[i-1]) fab_d[i] <= fab_d[i-1];
      end
    end
  end

  assign mem_rd_valid = spi_v[RD_LAT-1];
  assign mem_rd_data  = spi_d[RD_LAT-1];
  assign fab_rvalid   = fab_v[RD_LAT-1];
  assign fab_rdata    = fab_d[RD_LAT-1];

  assign reg_in_range_c = ({1'b0, reg_idx} < 8'(NUM_REGS));
  assign reg_wr_ok_c    = reg_wr_req & reg_in_range_c;
  assign ridx_c         = reg_idx[RW-1:0];
  assign oob_evt_c      = (mem_wr_en & wr_oob_c) | (mem_rd_req & rd_oob_c);
  assign oob_clr_c      = reg_wr_ok_c & (reg_idx == 7'd7) & reg_wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) scratch[i] <= 8'h00;
      r8      <= 8'h00;
      oob_err <= 1'b0;
    end else begin
      if (reg_wr_ok_c && reg_idx >= 7'd9) scratch[ridx_c] <= reg_wdata;
      if (reg_wr_ok_c && reg_idx == 7'd8) r8 <= reg_wdata;
      // A new event in the clearing cycle keeps the flag set
      oob_err <= (oob_err & ~oob_clr_c) | oob_evt_c;
    end
  end

`ifdef ESP32_SPI_DOORBELL_EN
  // Write wins over a same-cycle acknowledge
  always_ff @(posedge clk) begin
    if (rst) db_irq_q <= 1'b0;
    else if (reg_wr_ok_c && reg_idx == 7'd8) db_irq_q <= 1'b1;
    else if (db_ack) db_irq_q <= 1'b0;
  end
  assign db_data = r8;
`else
  logic unused_db_ack;
  assign unused_db_ack = db_ack;
  assign db_irq_q      = 1'b0;
  assign db_data       = 8'h00;
`endif
  assign db_irq = db_irq_q;

  always_comb begin
    reg_rdata = 8'h00;
    if (reg_in_range_c) begin
      case (reg_idx)
        7'd0:    reg_rdata = 8'h41;
        7'd1:    reg_rdata = 8'h32;
        7'd2:    reg_rdata = 8'h46;
        7'd3:    reg_rdata = 8'h50;
        7'd4:    reg_rdata = PROTO_VER;
        7'd5:    reg_rdata = CAP0;
        7'd6:    reg_rdata = CAP1;
        7'd7:    reg_rdata = {6'b0, db_irq_q, oob_err};
        7'd8:    reg_rdata = r8;
        default: reg_rdata = scratch[ridx_c];
      endcase
    end
  end

endmodule

// File: doc/esp32_spi_regmem.md
# esp32_spi_regmem

Parametrised register/memory backend for the ESP32 SPI protocol processor. It serves the processor's register and memory-space request ports and adds several features:
- configurable register count, memory-space count and memory depth;
- read-only identity/capability registers;
- out-of-bounds detection;
- a pipelined read path;
- an arbitrated fabric-side port, so other FPGA logic can share the memory spaces.

It sits between `esp32_spi_proto_proc` and the board's application logic.

## Interface
Parameters:
- `NUM_REGS`, 16: register count; power of two, 8..128.
- `MEM_AW`, 8: byte-address width of each memory space; 4..12.
- `NUM_SPACES`, 2: implemented memory spaces; 1..4.
- `RD_LAT`, 1: memory read latency in cycles; 1 or 2.
- `PROTO_VER`, 8'h02: value of reg4.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `reg_wr_req` in 1: register write strobe.
- `reg_idx` in 7: register index.
- `reg_wdata` in 8: register write data.
- `reg_rdata` out 8: register read data; combinational from `reg_idx`.
- `mem_wr_en` in 1: SPI memory write strobe.
- `mem_space` in 3: space for the SPI write.
- `mem_wr_addr` in 24: SPI write address.
- `mem_wr_data` in 8: SPI write data.
- `mem_rd_req` in 1: SPI memory read strobe.
- `mem_rd_space` in 3: space for the SPI read.
- `mem_rd_addr` in 24: SPI read address.
- `mem_rd_valid` out 1: SPI read data valid, one-cycle pulse.
- `mem_rd_data` out 8: SPI read data.
- `fab_req` in 1: fabric access request; held until granted.
- `fab_we` in 1: fabric write (1) or read (0).
- `fab_space` in 2: fabric space.
- `fab_addr` in `MEM_AW`: fabric address.
- `fab_wdata` in 8: fabric write data.
- `fab_gnt` out 1: fabric access accepted this cycle; combinational.
- `fab_rvalid` out 1: fabric read data valid, one-cycle pulse.
- `fab_rdata` out 8: fabric read data.
- `db_irq` out 1: doorbell pending.
- `db_data` out 8: last doorbell value.
- `db_ack` in 1: fabric clears the doorbell.

## Operation
Register map:
- reg0..3: "A","2","F","P".
- reg4: `PROTO_VER`.
- reg5 CAP0:
  - bit0 = 1;
  - bit1 = doorbell compiled in;
  - bit2 = (`RD_LAT`==2).
- reg6 CAP1: {`MEM_AW[3:0]`, `NUM_SPACES[3:0]`}.
- reg0..6 are read-only; writes to them are dropped.
- reg7 STATUS:
  - bit0 OOB error, sticky, write-1-to-clear;
  - bit1 mirrors `db_irq`;
  - other bits read 0.
- reg8 DOORBELL: see Configuration.
- reg9..`NUM_REGS`-1: read/write scratch, reset to 0x00.
- `reg_idx` ≥ `NUM_REGS`: reads 0x00; writes dropped; no error flagged.

Memory:
- `NUM_SPACES` × 2^`MEM_AW` bytes; contents are not reset.
- An access is out of bounds if the space is ≥ `NUM_SPACES`, or if any address bit above `MEM_AW`-1 is set. There is no aliasing.
- OOB write: dropped; sets STATUS.bit0.
- OOB read: returns 0xFF with normal valid timing; sets STATUS.bit0.
- Fabric addresses are always in range; a fabric space ≥ `NUM_SPACES` is handled like an SPI out-of-bounds access but does not set the error flag.

Arbitration (single memory port):
- SPI always has priority.
- `fab_gnt` = `fab_req` & !`mem_wr_en` & !`mem_rd_req`.
- The fabric holds `fab_req` and its operands stable until `fab_gnt`.

## Timing
- Register write takes effect on the next cycle. A read of the same index in the write cycle returns the old value.
- SPI read: request in cycle N; `mem_rd_valid` is high in cycle N+`RD_LAT` with the data. Fully pipelined; back-to-back requests every cycle are accepted.
- Fabric read granted in cycle N: `fab_rvalid`/`fab_rdata` in cycle N+`RD_LAT`.
- Read after write to the same address one cycle later returns the new data, from either port.
- Same-cycle STATUS.bit0 clear and new OOB event: the flag stays set.
- Reset values:
  - `mem_rd_valid` = 0, `mem_rd_data` = 0x00;
  - `fab_rvalid` = 0, `fab_rdata` = 0x00;
  - `db_irq` = 0, `db_data` = 0x00;
  - STATUS = 0, scratch registers = 0x00.
- Reset asserted mid-read flushes the read pipeline; no valid pulse is emitted after reset releases for a request issued before it.

## Configuration
Macro `ESP32_SPI_DOORBELL_EN`.

Defined:
- An SPI write to reg8 latches `reg_wdata` into `db_data` and sets `db_irq` on the next cycle.
- `db_ack` clears `db_irq` on the next cycle.
- A write and `db_ack` in the same cycle: the write wins and `db_irq` stays 1.
- reg8 reads back `db_data`.

Undefined:
- reg8 is plain scratch.
- `db_irq` and `db_data` are tied to 0.
- CAP0.bit1 = 0 and STATUS.bit1 = 0.

## Test plan
- Reset, then read reg0..6 → "A2FP", 0x02, CAP0 = 0x01 (defaults, doorbell undefined), CAP1 = 0x82. Write 0x55 to reg0 → still reads "A".
- SPI writes 0xA5 to space1 addr 0x3C, then reads it back with `RD_LAT`=2 → `mem_rd_valid` exactly 2 cycles after the request, data 0xA5. Four back-to-back reads of different addresses → four consecutive valid cycles with the correct data.
- SPI write to addr 0x000100 (`MEM_AW`=8) → memory unchanged, STATUS = 0x01. SPI read of space 3 → 0xFF. Write 0x01 to reg7 → STATUS = 0x00.
- `fab_req` held as a write while SPI issues 3 consecutive `mem_rd_req` → `fab_gnt` stays 0 for 3 cycles, then 1 for one cycle; a subsequent fabric read returns the written byte.
- With `ESP32_SPI_DOORBELL_EN`: write 0x7E to reg8 → `db_irq` = 1, `db_data` = 0x7E, STATUS = 0x02. Assert `db_ack` in the same cycle as a second reg8 write → `db_irq` remains 1.
- Assert `rst` one cycle after a `mem_rd_req` with `RD_LAT`=2 → no `mem_rd_valid` pulse, and all outputs at their reset values.
